// File: rtl/bus_err_tracker_if.sv
// Request/response bus lanes observed by the error tracker, one lane per channel.
interface bus_err_tracker_if #(
    parameter int NumChannels   = 2,
    parameter int AddrWidth     = 48,
    parameter int MetaDataWidth = 1,
    parameter int ErrBits       = 3
);
    // req_valid_i/rsp_valid_i qualify their lane for exactly one cycle each; there is no
    // ready: the tracker is a passive observer and consumes every beat flagged valid.
    logic [NumChannels-1:0]               req_valid_i;
    logic [NumChannels*AddrWidth-1:0]     req_addr_i;
    logic [NumChannels*MetaDataWidth-1:0] req_meta_i;
    logic [NumChannels-1:0]               rsp_valid_i;
    logic [NumChannels-1:0]               rsp_last_i;
    logic [NumChannels*ErrBits-1:0]       rsp_err_i;

    modport master (output req_valid_i, req_addr_i, req_meta_i, rsp_valid_i, rsp_last_i, rsp_err_i);
    modport slave  (input  req_valid_i, req_addr_i, req_meta_i, rsp_valid_i, rsp_last_i, rsp_err_i);
endinterface

// File: rtl/bus_err_tracker.sv
// Multi-channel bus error tracker: per-channel outstanding-address FIFOs and error staging,
// round-robin arbitration of staged errors into a shared error FIFO popped by software.
module bus_err_tracker #(
    parameter int AddrWidth       = 48,
    parameter int MetaDataWidth   = 1,
    parameter int ErrBits         = 3,
    parameter int NumOutstanding  = 4,
    parameter int NumStoredErrors = 4,
    parameter int NumChannels     = 2,
    parameter bit DropOldest      = 1'b0,
    parameter int CntWidth        = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    bus_err_tracker_if.slave         bus,
    input  logic [ErrBits-1:0]       err_mask_i,
    input  logic                     dead_clr_i,
    input  logic                     err_pop_i,
    output logic                     err_valid_o,
    output logic [ErrBits-1:0]       err_code_o,
    output logic [AddrWidth-1:0]     err_addr_o,
    output logic [MetaDataWidth-1:0] err_meta_o,
    output logic [((NumChannels > 1) ? $clog2(NumChannels) : 1)-1:0] err_chan_o,
    output logic                     err_overflow_o,
    input  logic                     err_overflow_clr_i,
    output logic [CntWidth-1:0]      err_count_o,
    output logic [NumChannels-1:0]   chan_dead_o
);
    localparam int ChanW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int AfPtrW = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int AfCntW = $clog2(NumOutstanding + 1);
    localparam int EfPtrW = (NumStoredErrors > 1) ? $clog2(NumStoredErrors) : 1;
    localparam int EfCntW = $clog2(NumStoredErrors + 1);
    localparam logic [CntWidth:0] CntMax = {1'b0, {CntWidth{1'b1}}};

    function automatic logic [AfPtrW-1:0] af_inc(input logic [AfPtrW-1:0] p);
        return (p == AfPtrW'(NumOutstanding - 1)) ? '0 : p + AfPtrW'(1);
    endfunction

    function automatic logic [EfPtrW-1:0] ef_inc(input logic [EfPtrW-1:0] p);
        return (p == EfPtrW'(NumStoredErrors - 1)) ? '0 : p + EfPtrW'(1);
    endfunction

    logic [AddrWidth-1:0]     r_af_addr [NumChannels][NumOutstanding];
    logic [MetaDataWidth-1:0] r_af_meta [NumChannels][NumOutstanding];
    logic [AfPtrW-1:0]        r_af_wptr [NumChannels];
    logic [AfPtrW-1:0]        r_af_rptr [NumChannels];
    logic [AfCntW-1:0]        r_af_cnt  [NumChannels];
    logic [NumChannels-1:0]   r_dead;

    logic [NumChannels-1:0]   r_st_valid;
    logic [ErrBits-1:0]       r_st_code [NumChannels];
    logic [AddrWidth-1:0]     r_st_addr [NumChannels];
    logic [MetaDataWidth-1:0] r_st_meta [NumChannels];

    logic [ErrBits-1:0]       r_ef_code [NumStoredErrors];
    logic [AddrWidth-1:0]     r_ef_addr [NumStoredErrors];
    logic [MetaDataWidth-1:0] r_ef_meta [NumStoredErrors];
    logic [ChanW-1:0]         r_ef_chan [NumStoredErrors];
    logic [EfPtrW-1:0]        r_ef_wptr;
    logic [EfPtrW-1:0]        r_ef_rptr;
    logic [EfCntW-1:0]        r_ef_cnt;

    logic [ChanW-1:0]         r_rr;
    logic [CntWidth-1:0]      r_count;
    logic                     r_ovf;

    logic [NumChannels-1:0]   w_af_full, w_af_empty, w_af_push, w_af_pop, w_dead_set;
    logic [NumChannels-1:0]   w_qual, w_st_load, w_st_drop, w_gnt;
    logic [ErrBits-1:0]       w_rsp_err   [NumChannels];
    logic [AddrWidth-1:0]     w_head_addr [NumChannels];
    logic [MetaDataWidth-1:0] w_head_meta [NumChannels];
    logic                     w_ef_full, w_ef_empty, w_ef_pop, w_ef_drop, w_ef_adv, w_can_push;
    logic                     w_gnt_any, w_ovf_set;
    logic [ChanW-1:0]         w_gnt_idx;
    logic [ChanW:0]           w_cand;
    logic [CntWidth:0]        w_qual_num, w_cnt_sum;

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        assign w_af_full[c]   = (r_af_cnt[c] == AfCntW'(NumOutstanding));
        assign w_af_empty[c]  = (r_af_cnt[c] == '0);
        assign w_af_push[c]   = bus.req_valid_i[c] & ~w_af_full[c] & ~r_dead[c];
        assign w_dead_set[c]  = bus.req_valid_i[c] & w_af_full[c];
        assign w_af_pop[c]    = bus.rsp_valid_i[c] & bus.rsp_last_i[c] & ~w_af_empty[c] & ~r_dead[c];
        assign w_rsp_err[c]   = bus.rsp_err_i[c*ErrBits +: ErrBits];
        assign w_qual[c]      = bus.rsp_valid_i[c] & (|(w_rsp_err[c] & ~err_mask_i));
        // Once tracking is lost the head no longer matches the beat, so report unknown.
        assign w_head_addr[c] = (r_dead[c] | w_af_empty[c]) ? '0 : r_af_addr[c][r_af_rptr[c]];
        assign w_head_meta[c] = (r_dead[c] | w_af_empty[c]) ? '0 : r_af_meta[c][r_af_rptr[c]];
        assign w_st_load[c]   = w_qual[c] & (~r_st_valid[c] | w_gnt[c]);
        assign w_st_drop[c]   = w_qual[c] & r_st_valid[c] & ~w_gnt[c];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || dead_clr_i) begin
            r_dead <= '0;
            for (int c = 0; c < NumChannels; c++) begin
                r_af_wptr[c] <= '0;
                r_af_rptr[c] <= '0;
                r_af_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (w_dead_set[c]) r_dead[c] <= 1'b1;
                if (w_af_push[c]) r_af_wptr[c] <= af_inc(r_af_wptr[c]);
                if (w_af_pop[c])  r_af_rptr[c] <= af_inc(r_af_rptr[c]);
                if (w_af_push[c] && !w_af_pop[c]) begin
                    r_af_cnt[c] <= r_af_cnt[c] + AfCntW'(1);
                end else if (!w_af_push[c] && w_af_pop[c]) begin
                    r_af_cnt[c] <= r_af_cnt[c] - AfCntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (w_af_push[c]) begin
                r_af_addr[c][r_af_wptr[c]] <= bus.req_addr_i[c*AddrWidth +: AddrWidth];
                r_af_meta[c][r_af_wptr[c]] <= bus.req_meta_i[c*MetaDataWidth +: MetaDataWidth];
            end
        end
    end

    assign w_ef_full  = (r_ef_cnt == EfCntW'(NumStoredErrors));
    assign w_ef_empty = (r_ef_cnt == '0);
    assign w_ef_pop   = err_pop_i & ~w_ef_empty;
    assign w_can_push = ~w_ef_full | err_pop_i | DropOldest;
    assign w_ef_drop  = w_gnt_any & w_ef_full & ~w_ef_pop;
    assign w_ef_adv   = w_ef_pop | w_ef_drop;

    // Round-robin search starting at r_rr; grant is withheld entirely under back-pressure.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NumChannels; i++) begin
            w_cand = {1'b0, r_rr} + (ChanW+1)'(i);
            if (w_cand >= (ChanW+1)'(NumChannels)) w_cand = w_cand - (ChanW+1)'(NumChannels);
            if (!w_gnt_any && w_can_push && r_st_valid[w_cand[ChanW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[ChanW-1:0];
            end
        end
    end

    assign w_gnt = w_gnt_any ? (NumChannels'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st_valid <= '0;
            r_rr       <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                if (w_st_load[c])  r_st_valid[c] <= 1'b1;
                else if (w_gnt[c]) r_st_valid[c] <= 1'b0;
            end
            if (w_gnt_any) begin
                r_rr <= (w_gnt_idx == ChanW'(NumChannels - 1)) ? '0 : w_gnt_idx + ChanW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChannels; c++) begin
            if (w_st_load[c]) begin
                r_st_code[c] <= w_rsp_err[c];
                r_st_addr[c] <= w_head_addr[c];
                r_st_meta[c] <= w_head_meta[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ef_wptr <= '0;
            r_ef_rptr <= '0;
            r_ef_cnt  <= '0;
        end else begin
            if (w_gnt_any) r_ef_wptr <= ef_inc(r_ef_wptr);
            if (w_ef_adv)  r_ef_rptr <= ef_inc(r_ef_rptr);
            if (w_gnt_any && !w_ef_adv)      r_ef_cnt <= r_ef_cnt + EfCntW'(1);
            else if (!w_gnt_any && w_ef_adv) r_ef_cnt <= r_ef_cnt - EfCntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_gnt_any) begin
            r_ef_code[r_ef_wptr] <= r_st_code[w_gnt_idx];
            r_ef_addr[r_ef_wptr] <= r_st_addr[w_gnt_idx];
            r_ef_meta[r_ef_wptr] <= r_st_meta[w_gnt_idx];
            r_ef_chan[r_ef_wptr] <= w_gnt_idx;
        end
    end

    always_comb begin
        w_qual_num = '0;
        for (int c = 0; c < NumChannels; c++) begin
            w_qual_num = w_qual_num + (CntWidth+1)'(w_qual[c]);
        end
    end

    assign w_cnt_sum = {1'b0, r_count} + w_qual_num;
    assign w_ovf_set = (|w_st_drop) | w_ef_drop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= (w_cnt_sum > CntMax) ? '1 : w_cnt_sum[CntWidth-1:0];
            if (w_ovf_set)               r_ovf <= 1'b1;
            else if (err_overflow_clr_i) r_ovf <= 1'b0;
        end
    end

    assign err_valid_o    = ~w_ef_empty;
    assign err_code_o     = w_ef_empty ? '0 : r_ef_code[r_ef_rptr];
    assign err_addr_o     = w_ef_empty ? '0 : r_ef_addr[r_ef_rptr];
    assign err_meta_o     = w_ef_empty ? '0 : r_ef_meta[r_ef_rptr];
    assign err_chan_o     = w_ef_empty ? '0 : r_ef_chan[r_ef_rptr];
    assign err_overflow_o = r_ovf;
    assign err_count_o    = r_count;
    assign chan_dead_o    = r_dead;
endmodule

// File: tb/tb_bus_err_tracker.sv
// Directed bench driving a DropOldest=0 and a DropOldest=1 tracker from one shared bus.
module tb_bus_err_tracker;
    localparam int EW = 1 + 3 + 1 + 48;

    logic clk, rst;
    logic [2:0] err_mask;
    logic dead_clr, err_pop, ovf_clr;

    logic        d0_valid, d1_valid, d0_meta, d1_meta, d0_chan, d1_chan, d0_ovf, d1_ovf;
    logic [2:0]  d0_code, d1_code;
    logic [47:0] d0_addr, d1_addr;
    logic [3:0]  d0_count, d1_count;
    logic [1:0]  d0_dead, d1_dead;
    logic [EW-1:0] d0_ent, d1_ent, mon_e0, mon_e1;

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int n_chk = 0;
    int n_fail = 0;

    bus_err_tracker_if #(.NumChannels(2), .AddrWidth(48), .MetaDataWidth(1), .ErrBits(3)) bus ();

    bus_err_tracker #(.AddrWidth(48), .MetaDataWidth(1), .ErrBits(3), .NumOutstanding(4),
                      .NumStoredErrors(4), .NumChannels(2), .DropOldest(1'b0), .CntWidth(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus), .err_mask_i(err_mask), .dead_clr_i(dead_clr),
        .err_pop_i(err_pop), .err_valid_o(d0_valid), .err_code_o(d0_code), .err_addr_o(d0_addr),
        .err_meta_o(d0_meta), .err_chan_o(d0_chan), .err_overflow_o(d0_ovf),
        .err_overflow_clr_i(ovf_clr), .err_count_o(d0_count), .chan_dead_o(d0_dead));

    bus_err_tracker #(.AddrWidth(48), .MetaDataWidth(1), .ErrBits(3), .NumOutstanding(4),
                      .NumStoredErrors(4), .NumChannels(2), .DropOldest(1'b1), .CntWidth(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus), .err_mask_i(err_mask), .dead_clr_i(dead_clr),
        .err_pop_i(err_pop), .err_valid_o(d1_valid), .err_code_o(d1_code), .err_addr_o(d1_addr),
        .err_meta_o(d1_meta), .err_chan_o(d1_chan), .err_overflow_o(d1_ovf),
        .err_overflow_clr_i(ovf_clr), .err_count_o(d1_count), .chan_dead_o(d1_dead));

    assign d0_ent = {d0_chan, d0_code, d0_meta, d0_addr};
    assign d1_ent = {d1_chan, d1_code, d1_meta, d1_addr};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [EW-1:0] ent(input logic ch, input logic [2:0] code,
                                          input logic meta, input logic [47:0] addr);
        return {ch, code, meta, addr};
    endfunction

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic req(input int ch, input logic [47:0] a, input logic m);
        bus.req_valid_i[ch]         = 1'b1;
        bus.req_addr_i[ch*48 +: 48] = a;
        bus.req_meta_i[ch]          = m;
        cyc(1);
        bus.req_valid_i = '0;
    endtask

    task automatic rsp(input logic [1:0] v, input logic [1:0] l, input logic [2:0] e0, input logic [2:0] e1);
        bus.rsp_valid_i = v;
        bus.rsp_last_i  = l;
        bus.rsp_err_i   = {e1, e0};
        cyc(1);
        bus.rsp_valid_i = '0;
        bus.rsp_last_i  = '0;
        bus.rsp_err_i   = '0;
    endtask

    task automatic pop();
        err_pop = 1'b1;
        cyc(1);
        err_pop = 1'b0;
    endtask

    task automatic push_both(input logic [EW-1:0] e);
        exp_q0.push_back(e);
        exp_q1.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares the FIFO head whenever software pops
    always @(negedge clk) begin
        if (!rst && err_pop) begin
            n_chk++;
            if (exp_q0.size() > 0) begin
                mon_e0 = exp_q0.pop_front();
                if (!d0_valid || d0_ent !== mon_e0) begin
                    n_fail++;
                    $display("FAIL pop_d0: got valid=%0b entry=%h, want entry=%h", d0_valid, d0_ent, mon_e0);
                end
            end else if (d0_valid) begin
                n_fail++;
                $display("FAIL pop_d0_empty: got valid=1 entry=%h, want valid=0", d0_ent);
            end
            n_chk++;
            if (exp_q1.size() > 0) begin
                mon_e1 = exp_q1.pop_front();
                if (!d1_valid || d1_ent !== mon_e1) begin
                    n_fail++;
                    $display("FAIL pop_d1: got valid=%0b entry=%h, want entry=%h", d1_valid, d1_ent, mon_e1);
                end
            end else if (d1_valid) begin
                n_fail++;
                $display("FAIL pop_d1_empty: got valid=1 entry=%h, want valid=0", d1_ent);
            end
        end
    end

    initial begin
        rst = 1'b1; err_mask = '0; dead_clr = 1'b0; err_pop = 1'b0; ovf_clr = 1'b0;
        bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_meta_i = '0;
        bus.rsp_valid_i = '0; bus.rsp_last_i = '0; bus.rsp_err_i = '0;
        cyc(2);
        chk("rst_valid", {d1_valid, d0_valid}, 0);
        chk("rst_count", {d1_count, d0_count}, 0);
        chk("rst_ovf", {d1_ovf, d0_ovf}, 0);
        chk("rst_dead", {d1_dead, d0_dead}, 0);
        chk("rst_head", {d0_code, d0_addr, d0_meta, d0_chan}, 0);
        rst = 1'b0;

        // two channels error together, RR pointer 0
        bus.req_valid_i = 2'b11;
        bus.req_addr_i  = {48'h3000, 48'h2000};
        bus.req_meta_i  = 2'b10;
        cyc(1);
        bus.req_valid_i = '0;
        rsp(2'b11, 2'b11, 3'd1, 3'd4);
        push_both(ent(1'b0, 3'd1, 1'b0, 48'h2000));
        push_both(ent(1'b1, 3'd4, 1'b1, 48'h3000));
        cyc(2);
        chk("dual_count", d0_count, 2);
        chk("dual_ovf", d0_ovf, 0);
        pop(); pop();
        chk("dual_drained", d0_valid, 0);

        // single error latency
        req(0, 48'h1000, 1'b1);
        rsp(2'b01, 2'b01, 3'd2, 3'd0);
        push_both(ent(1'b0, 3'd2, 1'b1, 48'h1000));
        chk("lat_not_fallthrough", d0_valid, 0);
        cyc(1);
        chk("lat_valid", d0_valid, 1);
        chk("lat_count", d0_count, 3);
        pop();

        // code mask
        err_mask = 3'b010;
        rsp(2'b10, 2'b10, 3'd0, 3'd2);
        cyc(2);
        chk("mask_no_entry", d0_valid, 0);
        chk("mask_count", d0_count, 3);
        rsp(2'b10, 2'b10, 3'd0, 3'd3);
        push_both(ent(1'b1, 3'd3, 1'b0, 48'h0));
        cyc(2);
        chk("mask_pass_count", d0_count, 4);
        pop();
        err_mask = 3'b000;

        // error on a non-last beat keeps the burst outstanding
        req(0, 48'h4444, 1'b0);
        rsp(2'b01, 2'b00, 3'd5, 3'd0);
        push_both(ent(1'b0, 3'd5, 1'b0, 48'h4444));
        rsp(2'b01, 2'b01, 3'd0, 3'd0);
        cyc(2);
        chk("beat_count", d0_count, 5);
        pop();

        // address FIFO overflow marks the channel dead
        for (int i = 1; i <= 4; i++) req(0, 48'h10 * i, 1'b0);
        chk("not_dead_at_depth", d0_dead, 2'b00);
        req(0, 48'h50, 1'b0);
        chk("dead_d0", d0_dead, 2'b01);
        chk("dead_d1", d1_dead, 2'b01);
        rsp(2'b01, 2'b01, 3'd1, 3'd0);
        push_both(ent(1'b0, 3'd1, 1'b0, 48'h0));
        cyc(2);
        pop();
        dead_clr = 1'b1;
        req(0, 48'h9999, 1'b1);
        dead_clr = 1'b0;
        chk("dead_cleared", d0_dead, 2'b00);
        rsp(2'b01, 2'b01, 3'd6, 3'd0);
        push_both(ent(1'b0, 3'd6, 1'b0, 48'h0));
        cyc(2);
        pop();
        req(0, 48'h7777, 1'b1);
        rsp(2'b01, 2'b01, 3'd7, 3'd0);
        push_both(ent(1'b0, 3'd7, 1'b1, 48'h7777));
        cyc(2);
        chk("dead_count", d0_count, 8);
        pop();

        // fill the error FIFO with back-to-back errors
        for (int i = 1; i <= 4; i++) begin
            rsp(2'b01, 2'b00, 3'(i), 3'd0);
            push_both(ent(1'b0, 3'(i), 1'b0, 48'h0));
        end
        cyc(2);
        chk("full_count", d0_count, 12);
        rsp(2'b01, 2'b00, 3'd5, 3'd0);
        exp_q0.push_back(ent(1'b0, 3'd5, 1'b0, 48'h0));
        void'(exp_q1.pop_front());
        exp_q1.push_back(ent(1'b0, 3'd5, 1'b0, 48'h0));
        cyc(2);
        chk("bp_ovf_d0", d0_ovf, 0);
        chk("drop_oldest_ovf_d1", d1_ovf, 1);
        chk("fifth_count", d0_count, 13);
        rsp(2'b01, 2'b00, 3'd6, 3'd0);
        void'(exp_q1.pop_front());
        exp_q1.push_back(ent(1'b0, 3'd6, 1'b0, 48'h0));
        cyc(2);
        chk("staged_drop_ovf_d0", d0_ovf, 1);
        chk("sixth_ovf_d1", d1_ovf, 1);
        chk("sixth_count", d0_count, 14);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", {d1_ovf, d0_ovf}, 2'b00);
        ovf_clr = 1'b1;
        rsp(2'b01, 2'b00, 3'd7, 3'd0);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", d0_ovf, 1);
        void'(exp_q1.pop_front());
        exp_q1.push_back(ent(1'b0, 3'd7, 1'b0, 48'h0));
        cyc(2);
        chk("seventh_ovf_d1", d1_ovf, 1);
        chk("max_count", d0_count, 15);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_clr2", {d1_ovf, d0_ovf}, 2'b00);
        repeat (5) pop();
        chk("drain_empty", {d1_valid, d0_valid}, 2'b00);

        // counter saturation, RR pointer now 1
        rsp(2'b11, 2'b00, 3'd1, 3'd2);
        push_both(ent(1'b1, 3'd2, 1'b0, 48'h0));
        push_both(ent(1'b0, 3'd1, 1'b0, 48'h0));
        cyc(3);
        chk("sat_count_d0", d0_count, 15);
        chk("sat_count_d1", d1_count, 15);
        pop(); pop();

        // reset in the middle of a burst
        req(1, 48'hABCD, 1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_count", d0_count, 0);
        chk("midrst_valid", d0_valid, 0);
        rsp(2'b10, 2'b10, 3'd0, 3'd1);
        push_both(ent(1'b1, 3'd1, 1'b0, 48'h0));
        cyc(2);
        chk("midrst_err_count", d0_count, 1);
        pop();
        chk("final_empty", {d1_valid, d0_valid}, 2'b00);
        chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
